// File: rtl/plot_pkg.sv
// plot_pkg
// Shared constants and types for the plotter pixel path. The frame
// dimensions here are the same ones the plotter uses for its frame limit,
// so the feeder and the plotter always agree on the image size.
//   PLOT_COLS / PLOT_ROWS : default image geometry
//   PIX_GRAY_W            : frame-buffer gray level width
//   feeder_state_t        : pixel feeder FSM states
package plot_pkg;

  localparam int PLOT_COLS  = 80;
  localparam int PLOT_ROWS  = 106;
  localparam int PIX_GRAY_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/plot_pixel_feeder_if.sv
// plot_pixel_feeder_if
// Bundles the feeder's control, frame-buffer and plotter handshake signals.
//   master : the feeder side (drives bram_addr, pixel/plotter outputs, status)
//   slave  : the environment side (start/threshold, BRAM data, plotter status)
// Signals:
//   start, threshold          : plot request and gray threshold
//   ready_next_pixel          : plotter consumed the presented pixel (level)
//   drawing_done              : plotter finished or hit its frame limit
//   bram_addr / bram_data     : frame-buffer read port
//   pixel_value_out           : 1 = dark pixel to draw
//   enable_plotter, busy, done: run enable and feeder status
//   col, row                  : position of the presented pixel
interface plot_pixel_feeder_if #(
  parameter int COLS   = plot_pkg::PLOT_COLS,
  parameter int ROWS   = plot_pkg::PLOT_ROWS,
  parameter int ADDR_W = $clog2(COLS * ROWS)
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic                            start;
  logic [plot_pkg::PIX_GRAY_W-1:0] threshold;
  logic                            ready_next_pixel;
  logic                            drawing_done;
  logic [ADDR_W-1:0]               bram_addr;
  logic [plot_pkg::PIX_GRAY_W-1:0] bram_data;
  logic                            pixel_value_out;
  logic                            enable_plotter;
  logic                            busy;
  logic                            done;
  logic [COL_W-1:0]                col;
  logic [ROW_W-1:0]                row;

  modport master (
    input  start, threshold, ready_next_pixel, drawing_done, bram_data,
    output bram_addr, pixel_value_out, enable_plotter, busy, done, col, row
  );

  modport slave (
    output start, threshold, ready_next_pixel, drawing_done, bram_data,
    input  bram_addr, pixel_value_out, enable_plotter, busy, done, col, row
  );

endinterface

// File: rtl/plot_pixel_feeder_rise_detect.sv
// rise_detect
// Registered rising-edge detector. rise_o is a one-cycle pulse on the
// clock after level_i goes from 0 to 1; a level held high pulses only once.
//   clk_65mhz : clock
//   rst       : synchronous, active-high reset
//   level_i   : level input to watch
//   rise_o    : registered rise pulse
module rise_detect (
  input  logic clk_65mhz,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;
  logic rise_q;

  // Remember the previous level and register the 0->1 transition.
  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_i;
      rise_q  <= level_i & ~level_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/plot_pixel_feeder.sv
// plot_pixel_feeder
// Reads a grayscale image from the frame-buffer BRAM in raster order,
// thresholds each pixel to one bit and hands it to the plotter one pixel
// per consumption edge of ready_next_pixel.
//   clk_65mhz : system clock
//   rst       : synchronous, active-high reset
//   bus       : plot_pixel_feeder_if master (start/threshold, BRAM port,
//               plotter handshake, status and pixel position)
module plot_pixel_feeder
  import plot_pkg::*;
#(
  parameter int COLS         = PLOT_COLS,
  parameter int ROWS         = PLOT_ROWS,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = $clog2(COLS * ROWS)
) (
  input  logic                clk_65mhz,
  input  logic                rst,
  plot_pixel_feeder_if.master bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

  feeder_state_t         state_q, state_d;
  logic [PIX_GRAY_W-1:0] thr_q, thr_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            latCnt_q, latCnt_d;
  logic                  pend_q, pend_d;
  logic                  pix_q, pix_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  enterDone;
  logic                  rise;

  rise_detect u_readyRise (
    .clk_65mhz (clk_65mhz),
    .rst       (rst),
    .level_i   (bus.ready_next_pixel),
    .rise_o    (rise)
  );

  // State and datapath registers.
  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      state_q  <= IDLE;
      thr_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      latCnt_q <= '0;
      pend_q   <= 1'b0;
      pix_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      latCnt_q <= latCnt_d;
      pend_q   <= pend_d;
      pix_q    <= pix_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. The address advances alongside col/row so it always
  // equals row*COLS+col without a multiplier. drawing_done is checked before
  // any consumption so an abort wins over a simultaneous rise.
  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    latCnt_d  = latCnt_q;
    pend_d    = pend_q;
    pix_d     = pix_q;
    en_d      = en_q;
    done_d    = done_q;
    enterDone = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          thr_d    = bus.threshold;
          col_d    = '0;
          row_d    = '0;
          addr_d   = '0;
          latCnt_d = '0;
          pend_d   = 1'b0;
          done_d   = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (bus.drawing_done) begin
          enterDone = 1'b1;
        end else begin
          // A rise during the fetch is remembered; further rises are dropped.
          if (rise) pend_d = 1'b1;
          if (latCnt_q == LAT_LAST) begin
            pix_d   = (bus.bram_data < thr_q);
            en_d    = 1'b1;
            state_d = PRESENT;
          end else begin
            latCnt_d = latCnt_q + 3'd1;
          end
        end
      end
      PRESENT: begin
        if (bus.drawing_done) begin
          enterDone = 1'b1;
        end else if (rise || pend_q) begin
          pend_d = 1'b0;
          if (col_q == COL_W'(COLS - 1) && row_q == ROW_W'(ROWS - 1)) begin
            enterDone = 1'b1;
          end else begin
            if (col_q == COL_W'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            addr_d   = addr_q + ADDR_W'(1);
            latCnt_d = '0;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enterDone) begin
      state_d = DONE;
      en_d    = 1'b0;
      pix_d   = 1'b0;
      done_d  = 1'b1;
      pend_d  = 1'b0;
    end
  end

  assign bus.bram_addr       = addr_q;
  assign bus.pixel_value_out = pix_q;
  assign bus.enable_plotter  = en_q;
  assign bus.busy            = (state_q == FETCH) || (state_q == PRESENT);
  assign bus.done            = done_q;
  assign bus.col             = col_q;
  assign bus.row             = row_q;

endmodule
